// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers one operand tile (A: ROWS x K, B: K x COLS)
// received as K valid/ready beats, then replays it with diagonal skew so that
// row i of A and column j of B reach the array edges i and j cycles late.
//
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   in_valid/in_ready  input beat handshake (in_ready high only in LOAD)
//   in_a               A column k, lane i = A[i][k]
//   in_b               B row k,    lane j = B[k][j]
//   in_last            final beat of the tile
//   a_in_bus/b_in_bus  skewed operand lanes to the array edges (registered)
//   valid_in           wavefront valid to the array origin (registered)
//   busy               high in FEED and DONE
//   done               one-cycle pulse after the feed window
module systolic_skew_feeder #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned K_MAX  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_a,
    input  logic [COLS*DATA_W-1:0] in_b,
    input  logic                   in_last,
    output logic [ROWS*DATA_W-1:0] a_in_bus,
    output logic [COLS*DATA_W-1:0] b_in_bus,
    output logic                   valid_in,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int unsigned KW = $clog2(K_MAX + 1);
    localparam int unsigned TW = $clog2(K_MAX + ROWS + COLS);

    typedef enum logic [1:0] {S_LOAD, S_FEED, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [KW-1:0]   k_len, klen_nxt;
    logic [TW-1:0]   t, t_nxt;
    logic [TW-1:0]   last_t;
    logic            xfer;
    logic            out_en;
    logic            valid_nxt;
    logic            done_nxt;
    logic            busy_nxt;
    logic [ROWS*DATA_W-1:0] a_nxt;
    logic [COLS*DATA_W-1:0] b_nxt;

    logic [DATA_W-1:0] buf_a [K_MAX][ROWS];
    logic [DATA_W-1:0] buf_b [K_MAX][COLS];
    logic [DATA_W-1:0] a_lane [ROWS];
    logic [DATA_W-1:0] b_lane [COLS];

    assign in_ready = (state == S_LOAD);
    assign xfer     = in_valid && (state == S_LOAD);
    assign last_t   = TW'(k_len) + TW'(ROWS + COLS - 2) - TW'(1);

    // Tile storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int i = 0; i < int'(ROWS); i++) buf_a[count][i] <= in_a[i*DATA_W +: DATA_W];
            for (int j = 0; j < int'(COLS); j++) buf_b[count][j] <= in_b[j*DATA_W +: DATA_W];
        end
    end

    // Next-state, counters and output enable
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        klen_nxt  = k_len;
        t_nxt     = t;
        out_en    = 1'b0;
        unique case (state)
            S_LOAD: begin
                if (xfer) begin
                    if (in_last || (count == CW'(K_MAX - 1))) begin
                        klen_nxt  = KW'(count) + KW'(1);
                        count_nxt = '0;
                        t_nxt     = '0;
                        state_nxt = S_FEED;
                        out_en    = 1'b1;
                    end else begin
                        count_nxt = count + CW'(1);
                    end
                end
            end
            S_FEED: begin
                if (t == last_t) begin
                    state_nxt = S_DONE;
                end else begin
                    t_nxt  = t + TW'(1);
                    out_en = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_LOAD;
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    // Skewed lane selection for next-state t. The entry written on the final
    // handshake edge is not yet in the buffer, so it is bypassed from the input.
    for (genvar i = 0; i < int'(ROWS); i++) begin : g_a
        logic [TW-1:0] d;
        logic [CW-1:0] idx;
        logic          hit;
        assign d      = t_nxt - TW'(i);
        assign idx    = CW'(d);
        assign hit    = out_en && (t_nxt >= TW'(i)) && (d < TW'(klen_nxt));
        assign a_lane[i] = !hit                    ? '0 :
                           (xfer && idx == count)  ? in_a[i*DATA_W +: DATA_W] :
                                                     buf_a[idx][i];
    end

    for (genvar j = 0; j < int'(COLS); j++) begin : g_b
        logic [TW-1:0] d;
        logic [CW-1:0] idx;
        logic          hit;
        assign d      = t_nxt - TW'(j);
        assign idx    = CW'(d);
        assign hit    = out_en && (t_nxt >= TW'(j)) && (d < TW'(klen_nxt));
        assign b_lane[j] = !hit                    ? '0 :
                           (xfer && idx == count)  ? in_b[j*DATA_W +: DATA_W] :
                                                     buf_b[idx][j];
    end

    // Pack lanes and derive registered status outputs
    always_comb begin
        a_nxt     = '0;
        b_nxt     = '0;
        for (int i = 0; i < int'(ROWS); i++) a_nxt[i*DATA_W +: DATA_W] = a_lane[i];
        for (int j = 0; j < int'(COLS); j++) b_nxt[j*DATA_W +: DATA_W] = b_lane[j];
        valid_nxt = out_en && (t_nxt < TW'(klen_nxt));
        done_nxt  = (state_nxt == S_DONE);
        busy_nxt  = (state_nxt != S_LOAD);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_LOAD;
            count    <= '0;
            k_len    <= '0;
            t        <= '0;
            a_in_bus <= '0;
            b_in_bus <= '0;
            valid_in <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            k_len    <= klen_nxt;
            t        <= t_nxt;
            a_in_bus <= a_nxt;
            b_in_bus <= b_nxt;
            valid_in <= valid_nxt;
            done     <= done_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed bench for systolic_skew_feeder with a
// per-cycle reference of the skewed lanes plus hand-computed spot values.
module tb_systolic_skew_feeder;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KM = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [R*DW-1:0] in_a;
    logic [C*DW-1:0] in_b;
    logic            in_last;
    logic [R*DW-1:0] a_in_bus;
    logic [C*DW-1:0] b_in_bus;
    logic            valid_in;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ma [R][KM];
    logic [DW-1:0] mb [KM][C];

    systolic_skew_feeder #(.DATA_W(DW), .ROWS(R), .COLS(C), .K_MAX(KM)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .a_in_bus (a_in_bus),
        .b_in_bus (b_in_bus),
        .valid_in (valid_in),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [R*DW-1:0] exp_a(input int t, input int k);
        logic [R*DW-1:0] v;
        v = '0;
        for (int i = 0; i < R; i++)
            if (t - i >= 0 && t - i < k) v[i*DW +: DW] = ma[i][t-i];
        return v;
    endfunction

    function automatic logic [C*DW-1:0] exp_b(input int t, input int k);
        logic [C*DW-1:0] v;
        v = '0;
        for (int j = 0; j < C; j++)
            if (t - j >= 0 && t - j < k) v[j*DW +: DW] = mb[t-j][j];
        return v;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < KM; k++) begin
            for (int i = 0; i < R; i++) ma[i][k] = DW'($urandom_range(255, 1));
            for (int j = 0; j < C; j++) mb[k][j] = DW'($urandom_range(255, 1));
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_a     = 'x;
        in_b     = 'x;
        in_last  = 'x;
    endtask

    // Entered at a negedge; returns at the negedge of feed cycle t=0.
    task automatic send_tile(input int k, input bit use_last, input int gap_max,
                             input bit hold, output int first_wait);
        int w;
        first_wait = 0;
        for (int bt = 0; bt < k; bt++) begin
            if (gap_max > 0) begin
                int n;
                n = $urandom_range(gap_max, 0);
                repeat (n) begin
                    idle_inputs();
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            for (int i = 0; i < R; i++) in_a[i*DW +: DW] = ma[i][bt];
            for (int j = 0; j < C; j++) in_b[j*DW +: DW] = mb[bt][j];
            in_last = use_last && (bt == k - 1);
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (bt == 0) first_wait = w;
            if (w >= 50) begin
                check("ready_timeout", 64'(in_ready), 64'd1);
                idle_inputs();
                return;
            end
            @(posedge clk);
            #1;
            if (hold && bt == k - 1) begin
                in_valid = 1'b1;
                in_a     = 32'hDEAD_BEEF;
                in_b     = 32'h5A5A_A5A5;
                in_last  = 1'b1;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
    endtask

    // Entered at the negedge of t=0; returns at the negedge of the DONE cycle.
    task automatic chk_feed(input string tag, input int k,
                            output logic [R*DW-1:0] a_t2, output logic [C*DW-1:0] b_t2,
                            output int vcnt);
        int f;
        f = k + R + C - 2;
        vcnt = 0;
        a_t2 = '0;
        b_t2 = '0;
        for (int t = 0; t < f; t++) begin
            check($sformatf("%s a t=%0d", tag, t), 64'(a_in_bus), 64'(exp_a(t, k)));
            check($sformatf("%s b t=%0d", tag, t), 64'(b_in_bus), 64'(exp_b(t, k)));
            check($sformatf("%s valid t=%0d", tag, t), 64'(valid_in), 64'(t < k));
            check($sformatf("%s ctl t=%0d", tag, t), 64'({busy, in_ready, done}), 64'(3'b100));
            if (valid_in === 1'b1) vcnt++;
            if (t == 2) begin
                a_t2 = a_in_bus;
                b_t2 = b_in_bus;
            end
            @(negedge clk);
        end
        check({tag, " done data"}, 64'({a_in_bus, b_in_bus, valid_in}), 64'd0);
        check({tag, " done ctl"}, 64'({busy, in_ready, done}), 64'(3'b101));
        idle_inputs();
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        check({tag, " idle data"}, 64'({a_in_bus, b_in_bus, valid_in}), 64'd0);
        check({tag, " idle ctl"}, 64'({busy, in_ready, done}), 64'(3'b010));
    endtask

    initial begin
        logic [R*DW-1:0] a2;
        logic [C*DW-1:0] b2;
        int vc;
        int fw;

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset data", 64'({a_in_bus, b_in_bus, valid_in}), 64'd0);
        check("reset ctl", 64'({busy, in_ready, done}), 64'(3'b010));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle x inputs", 64'({a_in_bus, b_in_bus, valid_in, busy, done}), 64'd0);

        // Basic K=3
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < R; i++) ma[i][k] = DW'(10 * i + k + 1);
            for (int j = 0; j < C; j++) mb[k][j] = DW'(10 * k + j + 1);
        end
        send_tile(3, 1'b1, 0, 1'b0, fw);
        chk_feed("basic", 3, a2, b2, vc);
        check("basic a t2", 64'(a2), 64'h0000_0000_0015_0C03);
        check("basic b t2", 64'(b2), 64'h0000_0000_0003_0C15);
        check("basic vcnt", 64'(vc), 64'd3);
        chk_idle("basic");

        // K=1
        for (int i = 0; i < R; i++) ma[i][0] = DW'(i + 1);
        for (int j = 0; j < C; j++) mb[0][j] = DW'(j + 5);
        send_tile(1, 1'b1, 0, 1'b0, fw);
        check("k1 t0 a", 64'(a_in_bus), 64'h0000_0000_0000_0001);
        check("k1 t0 b", 64'(b_in_bus), 64'h0000_0000_0000_0005);
        chk_feed("k1", 1, a2, b2, vc);
        check("k1 a t2", 64'(a2), 64'h0000_0000_0003_0000);
        check("k1 vcnt", 64'(vc), 64'd1);
        chk_idle("k1");

        // Forced last at K_MAX
        fill_random();
        send_tile(KM, 1'b0, 0, 1'b0, fw);
        chk_feed("forced", KM, a2, b2, vc);
        check("forced vcnt", 64'(vc), 64'd16);
        chk_idle("forced");

        // Backpressure gaps in LOAD, in_valid held through FEED/DONE
        fill_random();
        send_tile(5, 1'b1, 3, 1'b1, fw);
        chk_feed("bp", 5, a2, b2, vc);
        check("bp vcnt", 64'(vc), 64'd5);
        chk_idle("bp");

        // Async reset at t=4 of a K=3 feed
        fill_random();
        send_tile(3, 1'b1, 0, 1'b0, fw);
        repeat (4) @(negedge clk);
        check("rst pre a t4", 64'(a_in_bus), 64'(exp_a(4, 3)));
        #2 rst = 1'b1;
        #1;
        check("rst async data", 64'({a_in_bus, b_in_bus, valid_in}), 64'd0);
        check("rst async ctl", 64'({busy, in_ready, done}), 64'(3'b010));
        @(negedge clk);
        rst = 1'b0;
        begin
            int dseen;
            dseen = 0;
            repeat (12) begin
                @(negedge clk);
                if (done !== 1'b0 || valid_in !== 1'b0 || busy !== 1'b0) dseen++;
            end
            check("rst no done", 64'(dseen), 64'd0);
        end
        check("rst ready", 64'(in_ready), 64'd1);
        fill_random();
        send_tile(2, 1'b1, 0, 1'b0, fw);
        chk_feed("post rst", 2, a2, b2, vc);
        check("post rst vcnt", 64'(vc), 64'd2);
        chk_idle("post rst");

        // Back-to-back tiles
        fill_random();
        send_tile(3, 1'b1, 0, 1'b0, fw);
        chk_feed("b2b first", 3, a2, b2, vc);
        fill_random();
        send_tile(2, 1'b1, 0, 1'b0, fw);
        check("b2b first wait", 64'(fw), 64'd1);
        chk_feed("b2b second", 2, a2, b2, vc);
        check("b2b vcnt", 64'(vc), 64'd2);
        chk_idle("b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Upstream stage of the 2D wavefront systolic array. It buffers one operand tile, A (ROWS x K) and B (K x COLS), delivered as K beats over a valid/ready stream. It then replays the tile with diagonal skew: row i of A is delayed i cycles and column j of B is delayed j cycles. The result drives the array's left-edge A bus, top-edge B bus and wavefront valid directly.

Parameters:
DATA_W, 8, operand width (signed)
ROWS, 4, array rows; number of A lanes
COLS, 4, array columns; number of B lanes
K_MAX, 16, maximum inner dimension (buffer depth), >=1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  feeder can accept a beat
in_a  in  ROWS*DATA_W  A column k: lane i at bits [(i+1)*DATA_W-1 -: DATA_W] = A[i][k]
in_b  in  COLS*DATA_W  B row k: lane j = B[k][j]
in_last  in  1  marks final beat (k = K-1) of the tile
a_in_bus  out  ROWS*DATA_W  skewed A to array left edge, registered
b_in_bus  out  COLS*DATA_W  skewed B to array top edge, registered
valid_in  out  1  wavefront valid to array origin, registered
busy  out  1  high in FEED and DONE
done  out  1  one-cycle pulse at end of feed window

Behaviour:
- Reset (async, any state): state=LOAD, write count=0, k_len=0, feed counter t=0. a_in_bus=0, b_in_bus=0, valid_in=0, done=0, busy=0, in_ready=1. Buffer contents are not cleared; they are don't-care.
- Handshake: a beat transfers when in_valid & in_ready. Data is sampled only on a transfer. in_ready=1 only in LOAD; it is combinational from state.
- LOAD:
  - Each transfer writes in_a/in_b to buffer entry [count], then count++.
  - A transfer with in_last=1, or the transfer into entry K_MAX-1 (forced last), sets k_len=count+1, resets count=0 and t=0, and moves to FEED.
  - in_last on the first beat is legal (k_len=1).
  - Outputs are held at 0 in LOAD.
- FEED: lasts F = k_len+ROWS+COLS-2 cycles, t=0..F-1. Cycle t=0 is the first clock after the last handshake. In cycle t (registered outputs):
  - a lane i = A[i][t-i] if 0 <= t-i < k_len, else 0.
  - b lane j = B[t-j][j] if 0 <= t-j < k_len, else 0.
  - valid_in = 1 iff t < k_len.
  - Outputs update at the same edge that advances t. The output registers are fed from next-state t, so t=0 data is visible in the first FEED cycle.
- DONE: one cycle. Outputs are 0, done=1, busy=1. Next state is LOAD; in_ready rises in the following cycle.
- Latency: from the last handshake edge to the first skewed output is 1 cycle. From the last handshake to done is F+1 cycles.
- Arithmetic: data passes through unmodified, no sign change. Zero fill uses all-zero words. The t counter width is clog2(K_MAX+ROWS+COLS). The buffer index t-i is computed signed or compared before subtracting; it never wraps.
- Boundary cases:
  - in_valid held high during FEED/DONE is ignored; no transfer occurs.
  - in_last asserted when count already equals K_MAX-1 behaves the same as a forced last.
  - Inputs X while in_valid=0 must not propagate.
  - rst mid-FEED: outputs go to 0 immediately (async), no done pulse, and the tile is discarded.

Test Plan:
- Basic 4x4, K=3:
  - Stimulus: beat k carries A[i][k]=10*i+k+1 and B[k][j]=10*k+j+1. Last beat has in_last.
  - Expected: F=9 cycles; in cycle t=2, a lanes=(3,12,21,0) and b lanes=(21,12,3,0). valid_in high for t=0..2. done pulses at t=9.
- K=1 (in_last on the first beat):
  - Stimulus: A=(1,2,3,4), B=(5,6,7,8).
  - Expected: a lane i nonzero only at t=i; F=7; valid_in high for 1 cycle.
- Forced last, K=K_MAX=16:
  - Stimulus: send 16 beats with in_last=0.
  - Expected: FEED entered after the 16th beat; F=22; in_ready=0 from the next cycle until one cycle after done.
- Backpressure and gaps:
  - Stimulus: in_valid toggled randomly in LOAD; in_valid held high through FEED.
  - Expected: only LOAD transfers are stored; outputs match the model; in_ready=0 throughout FEED/DONE.
- Async reset at t=4 of a K=3 feed:
  - Expected: all outputs 0 without waiting for a clock edge; no done; in_ready=1 after reset release. A following K=2 tile feeds correctly.
- Back-to-back tiles:
  - Stimulus: a new tile is presented immediately after done.
  - Expected: first handshake occurs in the cycle after DONE; no stale lanes from the previous tile appear.
